// File: rtl/sid_bus_master_pkg.sv
// Shared definitions for the SID register-bus master.
// Contents:
//   - bus widths (address and data)
//   - the FSM state encoding
//   - SID register-map offsets (voices, filter, volume)
//   - a small helper used to size the shared phase counter
package sid_bus_master_pkg;

  localparam int SID_ADDR_W = 6;
  localparam int SID_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Voice register blocks: seven registers per voice.
  localparam logic [SID_ADDR_W-1:0] SID_VOICE1_BASE = 6'h00;
  localparam logic [SID_ADDR_W-1:0] SID_VOICE2_BASE = 6'h07;
  localparam logic [SID_ADDR_W-1:0] SID_VOICE3_BASE = 6'h0E;
  localparam int                    SID_VOICE_REGS  = 7;

  // Filter and master-volume registers.
  localparam logic [SID_ADDR_W-1:0] SID_FC_LO       = 6'h15;
  localparam logic [SID_ADDR_W-1:0] SID_FC_HI       = 6'h16;
  localparam logic [SID_ADDR_W-1:0] SID_RES_FILT    = 6'h17;
  localparam logic [SID_ADDR_W-1:0] SID_MODE_VOL    = 6'h18;

  // Read-only registers.
  localparam logic [SID_ADDR_W-1:0] SID_POT_X       = 6'h19;
  localparam logic [SID_ADDR_W-1:0] SID_POT_Y       = 6'h1A;
  localparam logic [SID_ADDR_W-1:0] SID_OSC3        = 6'h1B;
  localparam logic [SID_ADDR_W-1:0] SID_ENV3        = 6'h1C;

  // Largest of three values.
  // The phase counter must be wide enough for the longest bus phase.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sid_bus_master.sv
// Host-side initiator for the SID parallel register bus.
//
// Each accepted valid/ready request becomes one timed bus cycle:
//   SETUP  (address and write data stable, strobes high)
//   STROBE (CEb low, plus WEb for a write or OEb for a read)
//   HOLD   (strobes high, address and data still held)
// When the cycle completes, rsp_valid pulses for one clock.
//
// Ports:
//   wb_clk_i, rst_n                     clock; asynchronous active-low reset
//   req_valid/req_ready                 request handshake
//   req_we, req_addr, req_wdata         request payload
//   rsp_valid, rsp_rdata                completion pulse and last read data
//   bus_addr, bus_out, bus_oe, bus_in   SID address/data pins
//   CEb, WEb, OEb                       SID strobes, active low
//
// Every output is a flop, so the strobes cannot glitch.
module sid_bus_master
  import sid_bus_master_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [SID_ADDR_W-1:0] req_addr,
  input  logic [SID_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [SID_DATA_W-1:0] rsp_rdata,
  output logic [SID_ADDR_W-1:0] bus_addr,
  output logic [SID_DATA_W-1:0] bus_out,
  output logic                  bus_oe,
  input  logic [SID_DATA_W-1:0] bus_in,
  output logic                  CEb,
  output logic                  WEb,
  output logic                  OEb
);

  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("sid_bus_master: SETUP_CYC must be >= 1");
  end
  if (STROBE_CYC < 1) begin : g_bad_strobe
    $error("sid_bus_master: STROBE_CYC must be >= 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("sid_bus_master: HOLD_CYC must be >= 1");
  end

  localparam int MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // The counter is loaded with (phase length - 1) when a phase is entered.
  // The phase ends on the cycle where the counter reads zero.
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [SID_ADDR_W-1:0]   addr_d;
  logic [SID_DATA_W-1:0]   wdata_d;
  logic [SID_DATA_W-1:0]   rdata_d;
  logic                    rsp_d;
  logic                    ready_d;
  logic                    ceb_d, web_d, oeb_d, oe_d;
  logic                    last_cyc;

  assign last_cyc = (cnt_q == '0);

  // NOTE: every signal driven here gets a default before the case statement.
  // Otherwise a path that skips the assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = bus_addr;
    wdata_d = bus_out;
    rdata_d = rsp_rdata;
    rsp_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
          we_d    = req_we;
          addr_d  = req_addr;
          // A read leaves bus_out at its last value; it is not driven anyway.
          if (req_we) begin
            wdata_d = req_wdata;
          end
        end
      end
      ST_SETUP: begin
        if (last_cyc) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (last_cyc) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
          // Capture read data while OEb is still low.
          // The SID has had the whole strobe window to drive bus_in.
          if (!we_q) begin
            rdata_d = bus_in;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (last_cyc) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rsp_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pin values are decoded from the state being entered.
    // Because they are registered, they change on the same edge as the state.
    ready_d = (state_d == ST_IDLE);
    ceb_d   = (state_d != ST_STROBE);
    web_d   = !((state_d == ST_STROBE) && we_d);
    oeb_d   = !((state_d == ST_STROBE) && !we_d);
    oe_d    = we_d && (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // All flops then update together at the edge, with no ordering races.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      bus_addr  <= '0;
      bus_out   <= '0;
      bus_oe    <= 1'b0;
      CEb       <= 1'b1;
      WEb       <= 1'b1;
      OEb       <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      bus_addr  <= addr_d;
      bus_out   <= wdata_d;
      bus_oe    <= oe_d;
      CEb       <= ceb_d;
      WEb       <= web_d;
      OEb       <= oeb_d;
      rsp_valid <= rsp_d;
      rsp_rdata <= rdata_d;
      req_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_sid_bus_master.sv
// Self-checking bench for sid_bus_master.
//
// Checking is split into two parts:
//   - A scoreboard queue is filled when a request is accepted.
//     A monitor pops it on every rsp_valid and compares completion cycle
//     and read data.
//   - Directed sequences compare the pin waveform cycle by cycle.
//
// A small SID register model answers reads.
// A second instance with non-default timing covers the stretched bus cycle.
module tb_sid_bus_master;
  import sid_bus_master_pkg::*;

  logic       wb_clk_i = 1'b0;
  logic       rst_n;
  always #5 wb_clk_i = ~wb_clk_i;

  // Default-timing DUT.
  logic       req_valid, req_ready, req_we;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [5:0] bus_addr;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;
  logic       CEb, WEb, OEb;

  // Stretched-timing DUT (SETUP=2, STROBE=4, HOLD=3).
  logic       r6_valid, r6_ready, r6_we;
  logic [5:0] r6_addr;
  logic [7:0] r6_wdata;
  logic       r6_rsp_valid;
  logic [7:0] r6_rdata;
  logic [5:0] r6_bus_addr;
  logic [7:0] r6_bus_out;
  logic       r6_bus_oe;
  logic       r6_ceb, r6_web, r6_oeb;

  sid_bus_master u_dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bus_addr(bus_addr), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .CEb(CEb), .WEb(WEb), .OEb(OEb)
  );

  sid_bus_master #(.SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(3)) u_dut6 (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n),
    .req_valid(r6_valid), .req_ready(r6_ready), .req_we(r6_we),
    .req_addr(r6_addr), .req_wdata(r6_wdata),
    .rsp_valid(r6_rsp_valid), .rsp_rdata(r6_rdata),
    .bus_addr(r6_bus_addr), .bus_out(r6_bus_out), .bus_oe(r6_bus_oe),
    .bus_in(8'h00),
    .CEb(r6_ceb), .WEb(r6_web), .OEb(r6_oeb)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int accepts     = 0;
  int last_accept = 0;

  typedef struct {
    logic       we;
    logic [7:0] rdata;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem[64];
  logic [7:0] sid_mem[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SID model: drives register contents while the chip is read-enabled.
  assign bus_in = (!OEb && !CEb) ? sid_mem[bus_addr] : 8'h00;

  // Cycle counter, SID write port and request scoreboard feed.
  // For an accept at the edge ending cycle c, the response is due in cycle c+5.
  always @(posedge wb_clk_i) begin
    if (cyc == 0) begin
      for (int i = 0; i < 64; i++) begin
        ref_mem[i] = 8'(i * 7 + 3);
        sid_mem[i] = 8'(i * 7 + 3);
      end
      ref_mem[SID_OSC3] = 8'hA5;
      sid_mem[SID_OSC3] = 8'hA5;
    end else if (!CEb && !WEb && bus_oe) begin
      sid_mem[bus_addr] = bus_out;
    end
    if (rst_n && req_valid && req_ready) begin
      sb.push_back('{req_we, ref_mem[req_addr], cyc + 5});
      if (req_we) ref_mem[req_addr] = req_wdata;
      accepts++;
      last_accept = cyc;
    end
    cyc++;
  end

  // An aborted transaction must never answer.
  always @(negedge rst_n) sb.delete();

  // Monitor: bus invariants every cycle, plus the scoreboard pop on rsp_valid.
  always @(negedge wb_clk_i) begin
    if (rst_n) begin
      exp_t e;
      check("invariants",
            {(!WEb && !OEb), (bus_oe && !OEb), ((!WEb || !OEb) && CEb)}, 3'b000);
      check("invariants6",
            {(!r6_web && !r6_oeb), (r6_bus_oe && !r6_oeb),
             ((!r6_web || !r6_oeb) && r6_ceb)}, 3'b000);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_cycle", cyc, e.due);
          if (!e.we) check("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // One isolated request with default timing.
  // Waveform expected on cycles 1..5:
  //   SETUP=1, STROBE=2-3, HOLD=4, rsp_valid=5
  task automatic run_one(input logic we, input logic [5:0] addr,
                         input logic [7:0] wdata, input string tag);
    logic [4:0] exp_ctl;
    tick();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge wb_clk_i);
    check({tag, "_ready"}, req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      logic strobe;
      @(negedge wb_clk_i);
      strobe  = (k == 2 || k == 3);
      // {bus_oe, CEb, WEb, OEb, rsp_valid}
      exp_ctl = {we && (k <= 4), !strobe, !(strobe && we), !(strobe && !we), (k == 5)};
      check($sformatf("%s_ctl_c%0d", tag, k), {bus_oe, CEb, WEb, OEb, rsp_valid}, exp_ctl);
      check($sformatf("%s_addr_c%0d", tag, k), bus_addr, addr);
      if (we) check($sformatf("%s_data_c%0d", tag, k), bus_out, wdata);
    end
  endtask

  initial begin
    int a0, c0, n, strobe_cnt, web_cnt, first_low, rsp_k;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    r6_valid = 1'b0; r6_we = 1'b0; r6_addr = '0; r6_wdata = '0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("reset_ctl", {CEb, WEb, OEb, bus_oe, rsp_valid, req_ready}, 6'b111001);
    check("reset_data", {bus_addr, bus_out, rsp_rdata}, 22'h0);
    rst_n = 1'b1;

    // Write 0x18 <= 0x0F.
    run_one(1'b1, SID_MODE_VOL, 8'h0F, "t1_wr");
    // Read 0x1B; the SID model returns 0xA5.
    run_one(1'b0, SID_OSC3, 8'h00, "t2_rd");
    repeat (2) tick();

    // Back-to-back write then read of 0x05, req_valid held high.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h05; req_wdata = 8'h3C;
    @(negedge wb_clk_i);
    tick();
    c0 = last_accept;
    a0 = accepts;
    req_we = 1'b0;
    n = 0;
    while (accepts == a0 && n < 20) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
    check("t3_second_accept_gap", last_accept - c0, 5);
    repeat (8) tick();

    // req_valid toggling while busy must neither be accepted nor disturb
    // the transaction in flight.
    a0 = accepts;
    req_valid = 1'b1; req_we = 1'b1; req_addr = SID_VOICE3_BASE; req_wdata = 8'h77;
    @(negedge wb_clk_i);
    tick();
    for (int k = 1; k <= 4; k++) begin
      req_valid = k[0];
      req_we    = k[1];
      req_addr  = 6'(6'h20 + k);
      req_wdata = 8'(8'hF0 + k);
      @(negedge wb_clk_i);
      if (k == 2 || k == 3) check($sformatf("t4_strobe_c%0d", k), {CEb, WEb}, 2'b00);
      check($sformatf("t4_latched_c%0d", k), {bus_addr, bus_out}, {SID_VOICE3_BASE, 8'h77});
      tick();
    end
    req_valid = 1'b0;
    check("t4_accepts", accepts - a0, 1);
    repeat (3) tick();
    run_one(1'b0, SID_VOICE3_BASE, 8'h00, "t4_rd");

    // Reset during the STROBE phase of a write.
    tick();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h10; req_wdata = 8'h99;
    @(negedge wb_clk_i);
    tick();
    req_valid = 1'b0;
    tick();                                  // into cycle 2
    @(negedge wb_clk_i);
    check("t5_in_strobe", {CEb, WEb}, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_abort", {CEb, WEb, OEb, bus_oe, rsp_valid}, 5'b11100);
    repeat (2) @(posedge wb_clk_i);
    #1 rst_n = 1'b1;
    @(negedge wb_clk_i);
    check("t5_ready_after_reset", req_ready, 1'b1);
    repeat (6) tick();
    run_one(1'b0, SID_MODE_VOL, 8'h00, "t5_rd");

    // Stretched timing: strobe low for 4 cycles, response in cycle 10.
    tick();
    r6_valid = 1'b1; r6_we = 1'b1; r6_addr = SID_FC_LO; r6_wdata = 8'h5A;
    @(negedge wb_clk_i);
    tick();
    r6_valid = 1'b0;
    strobe_cnt = 0; web_cnt = 0; first_low = 0; rsp_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge wb_clk_i);
      if (!r6_ceb) begin
        strobe_cnt++;
        if (first_low == 0) first_low = k;
      end
      if (!r6_web) web_cnt++;
      if (r6_rsp_valid) rsp_k = k;
    end
    check("t6_strobe_len", strobe_cnt, 4);
    check("t6_web_len", web_cnt, 4);
    check("t6_first_strobe", first_low, 3);
    check("t6_rsp_cycle", rsp_k, 10);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
